// File: rtl/mfp_mac_scheduler.sv
// Burst-granular round-robin scheduler for a shared fixed-point MAC with saturated output.
// Optional macro MFP_MAC_SCHED_RSHIFT_EN enables a rounded right shift by FRAC before saturation.
module mfp_mac_scheduler #(
    parameter int NREQ        = 2,
    parameter int In1W        = 8,
    parameter int In2W        = 8,
    parameter int GUARD       = 4,
    parameter int OutW        = 8,
    parameter int IS_UNSIGNED = 0,
    parameter int FRAC        = 0
) (
    input  logic                   clk_,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_last,
    input  logic [NREQ*In1W-1:0]   req_a,
    input  logic [NREQ*In2W-1:0]   req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [OutW-1:0]        res_data,
    output logic [1:0]             res_id,
    output logic                   res_sat,
    output logic                   busy
);
    localparam int PW   = In1W + In2W;
    localparam int AccW = PW + GUARD;
`ifdef MFP_MAC_SCHED_RSHIFT_EN
    localparam int SHIFT = FRAC;
`else
    localparam int SHIFT = 0 * FRAC;
`endif
    localparam int I_MAX = (IS_UNSIGNED != 0) ? (2**OutW - 1) : (2**(OutW-1) - 1);
    localparam int I_MIN = (IS_UNSIGNED != 0) ? 0 : -(2**(OutW-1));
    localparam int I_RND = (SHIFT > 0) ? (2**(SHIFT-1)) : 0;
    localparam logic signed [AccW+1:0] SAT_MAX = (AccW+2)'(I_MAX);
    localparam logic signed [AccW+1:0] SAT_MIN = (AccW+2)'(I_MIN);
    localparam logic signed [AccW+1:0] RND     = (AccW+2)'(I_RND);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;
    state_t r_state, w_state_next;

    logic [1:0]             r_grant, r_rr_ptr, w_arb_idx, w_idx_hi, w_idx_lo;
    logic                   w_arb_hit, w_hit_hi, w_hit_lo;
    logic [In1W-1:0]        w_a;
    logic [In2W-1:0]        w_b;
    logic                   w_gnt_valid, w_gnt_last, w_beat;
    logic [PW-1:0]          r_prod, w_prod;
    logic                   r_prod_vld;
    logic [AccW-1:0]        r_acc, w_prod_ext;
    logic signed [AccW+1:0] w_ext, w_shv;
    logic [OutW-1:0]        w_sat_data;
    logic                   w_sat;

    // Lowest valid index at/after the pointer wins; otherwise lowest index below it.
    always_comb begin
        w_hit_hi = 1'b0;
        w_hit_lo = 1'b0;
        w_idx_hi = '0;
        w_idx_lo = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            if (req_valid[k]) begin
                if (2'(k) >= r_rr_ptr) begin
                    w_hit_hi = 1'b1;
                    w_idx_hi = 2'(k);
                end else begin
                    w_hit_lo = 1'b1;
                    w_idx_lo = 2'(k);
                end
            end
        end
        w_arb_hit = w_hit_hi | w_hit_lo;
        w_arb_idx = w_hit_hi ? w_idx_hi : w_idx_lo;
    end

    always_comb begin
        w_a         = '0;
        w_b         = '0;
        w_gnt_valid = 1'b0;
        w_gnt_last  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (r_grant == 2'(k)) begin
                w_a         = req_a[k*In1W +: In1W];
                w_b         = req_b[k*In2W +: In2W];
                w_gnt_valid = req_valid[k];
                w_gnt_last  = req_last[k];
            end
        end
    end

    assign w_beat = (r_state == S_RUN) && w_gnt_valid;

    generate
        if (IS_UNSIGNED != 0) begin : g_unsigned
            assign w_prod     = w_a * w_b;
            assign w_prod_ext = {{GUARD{1'b0}}, r_prod};
        end else begin : g_signed
            assign w_prod     = $signed(w_a) * $signed(w_b);
            assign w_prod_ext = {{GUARD{r_prod[PW-1]}}, r_prod};
        end
    endgenerate

    always_ff @(posedge clk_ or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk_ or negedge rst_n) begin
        if (!rst_n) begin
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
        end else begin
            r_prod_vld <= w_beat;
            if (w_beat) r_prod <= w_prod;
            if (r_state == S_IDLE && w_arb_hit) begin
                r_grant <= w_arb_idx;
                r_acc   <= '0;
            end else if (r_prod_vld) begin
                r_acc <= r_acc + w_prod_ext;
            end
            if (r_state == S_OUT && res_ready)
                r_rr_ptr <= (r_grant == 2'(NREQ-1)) ? 2'd0 : r_grant + 2'd1;
        end
    end

    // DRAIN lasts one cycle: the final product lands in the accumulator on its exit edge.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_arb_hit) w_state_next = S_RUN;
            S_RUN:   if (w_beat && w_gnt_last) w_state_next = S_DRAIN;
            S_DRAIN: w_state_next = S_OUT;
            S_OUT:   if (res_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ext = (IS_UNSIGNED != 0) ? {2'b00, r_acc} : {{2{r_acc[AccW-1]}}, r_acc};
        w_shv = (w_ext + RND) >>> SHIFT;
        w_sat = 1'b1;
        if (w_shv > SAT_MAX)      w_sat_data = SAT_MAX[OutW-1:0];
        else if (w_shv < SAT_MIN) w_sat_data = SAT_MIN[OutW-1:0];
        else begin
            w_sat_data = w_shv[OutW-1:0];
            w_sat      = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (r_state == S_RUN) begin
            for (int k = 0; k < NREQ; k++) req_ready[k] = (r_grant == 2'(k));
        end
        res_valid = (r_state == S_OUT);
        res_data  = res_valid ? w_sat_data : '0;
        res_id    = res_valid ? r_grant : 2'd0;
        res_sat   = res_valid & w_sat;
        busy      = (r_state != S_IDLE);
    end
endmodule

// File: tb/tb_mfp_mac_scheduler.sv
// Directed bench: signed main instance plus unsigned and FRAC=2 instances sharing stimulus.
module tb_mfp_mac_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid, req_last;
    logic [15:0] req_a, req_b;
    logic        res_ready;

    logic [1:0] m_req_ready, u_req_ready, f_req_ready;
    logic       m_res_valid, u_res_valid, f_res_valid;
    logic [7:0] m_res_data, u_res_data, f_res_data;
    logic [1:0] m_res_id, u_res_id, f_res_id;
    logic       m_res_sat, u_res_sat, f_res_sat;
    logic       m_busy, u_busy, f_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mfp_mac_scheduler #(.NREQ(2), .IS_UNSIGNED(0), .FRAC(0)) u_main (
        .clk_(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
        .req_a(req_a), .req_b(req_b), .req_ready(m_req_ready), .res_valid(m_res_valid),
        .res_ready(res_ready), .res_data(m_res_data), .res_id(m_res_id),
        .res_sat(m_res_sat), .busy(m_busy));

    mfp_mac_scheduler #(.NREQ(2), .IS_UNSIGNED(1), .FRAC(0)) u_uns (
        .clk_(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
        .req_a(req_a), .req_b(req_b), .req_ready(u_req_ready), .res_valid(u_res_valid),
        .res_ready(res_ready), .res_data(u_res_data), .res_id(u_res_id),
        .res_sat(u_res_sat), .busy(u_busy));

    mfp_mac_scheduler #(.NREQ(2), .IS_UNSIGNED(0), .FRAC(2)) u_frac (
        .clk_(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
        .req_a(req_a), .req_b(req_b), .req_ready(f_req_ready), .res_valid(f_res_valid),
        .res_ready(res_ready), .res_data(f_res_data), .res_id(f_res_id),
        .res_sat(f_res_sat), .busy(f_busy));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge; returns at the negedge right after the beat was accepted.
    task automatic send(input int r, input logic [7:0] a, input logic [7:0] b, input logic last);
        int n;
        req_valid[r] = 1'b1;
        req_a[r*8 +: 8] = a;
        req_b[r*8 +: 8] = b;
        req_last[r] = last;
        n = 0;
        while (!m_req_ready[r] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("beat_ready_seen", {31'd0, m_req_ready[r]}, 32'd1);
        @(negedge clk);
        req_valid[r] = 1'b0;
        req_last[r]  = 1'b0;
    endtask

    task automatic wait_res();
        int n;
        n = 0;
        while (!m_res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("res_valid_seen", {31'd0, m_res_valid}, 32'd1);
    endtask

    initial begin : stim
        int got;
        int cyc;
        logic [1:0] exp_id [4];
        logic [7:0] exp_dat [4];
        exp_id  = '{2'd0, 2'd1, 2'd0, 2'd1};
        exp_dat = '{8'd1, 8'd4, 8'd1, 8'd4};
        req_valid = '0; req_last = '0; req_a = '0; req_b = '0; res_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {30'd0, m_req_ready}, 32'd0);
        chk("rst_res_valid", {31'd0, m_res_valid}, 32'd0);
        chk("rst_res_data", {24'd0, m_res_data}, 32'd0);
        chk("rst_res_id", {30'd0, m_res_id}, 32'd0);
        chk("rst_res_sat", {31'd0, m_res_sat}, 32'd0);
        chk("rst_busy", {31'd0, m_busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: three-beat dot product, exact two-cycle latency
        send(0, 8'd3, 8'd4, 1'b0);
        send(0, 8'hFE, 8'd5, 1'b0);
        send(0, 8'd10, 8'd10, 1'b1);
        chk("t1_valid_at_t1", {31'd0, m_res_valid}, 32'd0);
        chk("t1_busy_drain", {31'd0, m_busy}, 32'd1);
        @(negedge clk);
        chk("t1_valid_at_t2", {31'd0, m_res_valid}, 32'd1);
        chk("t1_data", {24'd0, m_res_data}, 32'd102);
        chk("t1_id", {30'd0, m_res_id}, 32'd0);
        chk("t1_sat", {31'd0, m_res_sat}, 32'd0);
        @(negedge clk);
        chk("t1_idle_valid", {31'd0, m_res_valid}, 32'd0);
        chk("t1_idle_busy", {31'd0, m_busy}, 32'd0);

        // 2: saturation high, low, and unsigned
        send(1, 8'd127, 8'd127, 1'b1);
        wait_res();
        chk("t2a_data", {24'd0, m_res_data}, 32'h7F);
        chk("t2a_sat", {31'd0, m_res_sat}, 32'd1);
        chk("t2a_id", {30'd0, m_res_id}, 32'd1);
        @(negedge clk);
        send(1, 8'h80, 8'd127, 1'b1);
        wait_res();
        chk("t2b_data", {24'd0, m_res_data}, 32'h80);
        chk("t2b_sat", {31'd0, m_res_sat}, 32'd1);
        @(negedge clk);
        send(1, 8'hFF, 8'hFF, 1'b1);
        wait_res();
        chk("t2c_signed_data", {24'd0, m_res_data}, 32'h01);
        chk("t2c_signed_sat", {31'd0, m_res_sat}, 32'd0);
        chk("t2c_uns_data", {24'd0, u_res_data}, 32'hFF);
        chk("t2c_uns_sat", {31'd0, u_res_sat}, 32'd1);
        @(negedge clk);

        // 3: two requesters continuously valid, round-robin alternation
        req_a = {8'd2, 8'd1};
        req_b = {8'd2, 8'd1};
        req_last = 2'b11;
        req_valid = 2'b11;
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            chk("t3_not_both_ready", {31'd0, (m_req_ready == 2'b11)}, 32'd0);
            if (m_res_valid) begin
                chk("t3_id", {30'd0, m_res_id}, {30'd0, exp_id[got]});
                chk("t3_data", {24'd0, m_res_data}, {24'd0, exp_dat[got]});
                got++;
                if (got == 4) begin
                    req_valid = 2'b00;
                    req_last  = 2'b00;
                end
            end
        end
        chk("t3_result_count", got, 32'd4);
        @(negedge clk);

        // 4: back-pressure in OUT, then grant moves to the other requester
        res_ready = 1'b0;
        send(0, 8'd7, 8'd3, 1'b1);
        wait_res();
        req_a = {8'd6, 8'd1};
        req_b = {8'd6, 8'd1};
        req_last = 2'b11;
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", {31'd0, m_res_valid}, 32'd1);
            chk("t4_hold_data", {24'd0, m_res_data}, 32'd21);
            chk("t4_hold_id", {30'd0, m_res_id}, 32'd0);
            chk("t4_hold_ready", {30'd0, m_req_ready}, 32'd0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("t4_idle_busy", {31'd0, m_busy}, 32'd0);
        chk("t4_idle_valid", {31'd0, m_res_valid}, 32'd0);
        @(negedge clk);
        chk("t4_next_grant", {30'd0, m_req_ready}, 32'd2);
        @(negedge clk);
        req_valid = 2'b00;
        req_last  = 2'b00;
        wait_res();
        chk("t4_next_id", {30'd0, m_res_id}, 32'd1);
        chk("t4_next_data", {24'd0, m_res_data}, 32'd36);
        @(negedge clk);

        // 5: asynchronous reset mid-burst discards the partial sum
        send(0, 8'd9, 8'd9, 1'b0);
        send(0, 8'd9, 8'd9, 1'b0);
        chk("t5_busy_before", {31'd0, m_busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", {31'd0, m_busy}, 32'd0);
        chk("t5_rst_ready", {30'd0, m_req_ready}, 32'd0);
        chk("t5_rst_valid", {31'd0, m_res_valid}, 32'd0);
        chk("t5_rst_data", {24'd0, m_res_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(0, 8'd5, 8'd5, 1'b1);
        wait_res();
        chk("t5_data", {24'd0, m_res_data}, 32'd25);
        chk("t5_id", {30'd0, m_res_id}, 32'd0);
        chk("t5_sat", {31'd0, m_res_sat}, 32'd0);
        @(negedge clk);

        // 6: bubble inside a burst, optional rounded shift
        send(0, 8'd3, 8'd3, 1'b0);
        @(negedge clk);
        send(0, 8'd1, 8'd1, 1'b1);
        wait_res();
        chk("t6_main_data", {24'd0, m_res_data}, 32'd10);
`ifdef MFP_MAC_SCHED_RSHIFT_EN
        chk("t6_frac_data", {24'd0, f_res_data}, 32'd3);
`else
        chk("t6_frac_data", {24'd0, f_res_data}, 32'd10);
`endif
        chk("t6_frac_sat", {31'd0, f_res_sat}, 32'd0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
